// File: rtl/c17_bist_pkg.sv
// c17_bist_pkg: shared state enum, MISR defaults and the c17 golden model.
package c17_bist_pkg;
  typedef enum logic [2:0] {IDLE, APPLY, WAIT, CAPTURE, FINISH} state_t;
  localparam logic [15:0] DEF_MISR_POLY = 16'h1021;
  localparam logic [15:0] DEF_MISR_SEED = 16'hFFFF;
  function automatic logic [1:0] c17_model(input logic [4:0] p);
    logic n1, n2, n3, n6, n7;
    {n1, n2, n3, n6, n7} = p;
    return {(n1 & n3) | (n2 & ~(n3 & n6)), ~(n3 & n6) & (n2 | n7)};
  endfunction
endpackage

// File: rtl/c17_misr.sv
// c17_misr: 16-bit MISR compacting the 2-bit c17 response each enabled cycle.
module c17_misr
  import c17_bist_pkg::*;
#(
  parameter logic [15:0] POLY = DEF_MISR_POLY,
  parameter logic [15:0] SEED = DEF_MISR_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        en,
  input  logic [1:0]  d,
  output logic [15:0] sig
);
  always_ff @(posedge clk or posedge rst)
    if (rst) sig <= SEED;
    else if (load) sig <= SEED;
    else if (en) sig <= {sig[14:0], 1'b0} ^ (sig[15] ? POLY : 16'h0) ^ {14'b0, d};
endmodule

// File: rtl/c17_bist.sv
// c17_bist: exhaustive pattern driver and response checker for the c17 core.
module c17_bist
  import c17_bist_pkg::*;
#(
  parameter int          NUM_PAT   = 32,
  parameter int          SETTLE    = 1,
  parameter logic [15:0] MISR_POLY = DEF_MISR_POLY,
  parameter logic [15:0] MISR_SEED = DEF_MISR_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [4:0]  dut_in,
  input  logic [1:0]  dut_out,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [5:0]  err_count,
  output logic [4:0]  first_err_pat,
  output logic [15:0] signature
);
  state_t state, nxt;
  logic [5:0] pat;
  logic [3:0] wcnt;
  logic go, cap, last, mism;
  assign go   = state == IDLE && start;
  assign cap  = state == CAPTURE;
  assign last = pat == 6'(NUM_PAT - 1);
  assign mism = dut_out != c17_model(dut_in);
  assign busy = state == APPLY || state == WAIT || state == CAPTURE;
  assign done = state == FINISH;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = start ? APPLY : IDLE;
      APPLY:   nxt = SETTLE > 0 ? WAIT : CAPTURE;
      WAIT:    nxt = wcnt == 4'd0 ? CAPTURE : WAIT;
      CAPTURE: nxt = last ? FINISH : APPLY;
      FINISH:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // pat is one bit wider than dut_in so NUM_PAT=32 reaches its last index cleanly
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pat           <= '0;
      wcnt          <= '0;
      dut_in        <= '0;
      err_count     <= '0;
      first_err_pat <= '0;
      pass          <= 1'b0;
    end else if (go) begin
      pat       <= '0;
      dut_in    <= '0;
      err_count <= '0;
      pass      <= 1'b0;
    end else if (state == APPLY) begin
      wcnt <= 4'(SETTLE - 1);
    end else if (state == WAIT) begin
      wcnt <= wcnt - 4'd1;
    end else if (cap) begin
      if (mism) begin
        err_count <= err_count == 6'd63 ? err_count : err_count + 6'd1;
        if (err_count == 6'd0) first_err_pat <= pat[4:0];
      end
      if (!last) begin
        pat    <= pat + 6'd1;
        dut_in <= 5'(pat + 6'd1);
      end
    end else if (done) begin
      pass <= err_count == 6'd0;
    end
  c17_misr #(.POLY(MISR_POLY), .SEED(MISR_SEED)) u_misr (
    .clk  (clk),
    .rst  (rst),
    .load (go),
    .en   (cap),
    .d    (dut_out),
    .sig  (signature)
  );
endmodule

// File: tb/tb_c17_bist.sv
// tb_c17_bist: directed checks of c17_bist against a gate-level c17 with injectable faults.
module tb_c17_bist;
  logic clk = 0, rst = 1, start_a = 0, start_b = 0;
  logic [4:0] dut_in_a, dut_in_b, fpat_a, fpat_b;
  logic [1:0] dut_out_a, dut_out_b;
  logic busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [5:0] err_a, err_b;
  logic [15:0] sig_a, sig_b;
  int fault = 0, checks = 0, failures = 0;
  always #5 clk = ~clk;
  function automatic logic [1:0] tb_c17(input logic [4:0] v, input int mode);
    logic n10, n11, n16, n19, n22, n23;
    n10 = ~(v[4] & v[2]);
    n11 = ~(v[2] & v[1]);
    n16 = ~(v[3] & n11);
    n19 = ~(n11 & v[0]);
    n22 = ~(n10 & n16);
    n23 = ~(n16 & n19);
    if (mode == 1) n22 = 1'b0;
    if (mode == 2) n23 = 1'b1;
    return {n22, n23};
  endfunction
  function automatic logic [15:0] exp_sig(input int mode, input int n);
    logic [15:0] s = 16'hFFFF;
    for (int p = 0; p < n; p++)
      s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0) ^ {14'b0, tb_c17(5'(p), mode)};
    return s;
  endfunction
  assign dut_out_a = tb_c17(dut_in_a, fault);
  assign dut_out_b = tb_c17(dut_in_b, 0);
  c17_bist #(.NUM_PAT(32), .SETTLE(1)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .dut_in(dut_in_a), .dut_out(dut_out_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .first_err_pat(fpat_a), .signature(sig_a));
  c17_bist #(.NUM_PAT(1), .SETTLE(0)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .dut_in(dut_in_b), .dut_out(dut_out_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .first_err_pat(fpat_b), .signature(sig_b));
  task automatic run(input bit which_b, input int pulse_at, output int done_cyc, output bit busy_ok);
    bit d, b;
    if (which_b) start_b = 1; else start_a = 1;
    @(posedge clk); #1;
    start_a = 0; start_b = 0;
    done_cyc = -1; busy_ok = 1;
    for (int c = 1; c <= 300 && done_cyc < 0; c++) begin
      if (!which_b) start_a = (c == pulse_at);
      d = which_b ? done_b : done_a;
      b = which_b ? busy_b : busy_a;
      if (d) begin
        done_cyc = c;
        if (b) busy_ok = 0;
      end else if (!b) busy_ok = 0;
      if (done_cyc < 0) begin @(posedge clk); #1; end
    end
    start_a = 0;
  endtask
  task automatic test_reset;
    checks++; if (dut_in_a !== 5'd0) begin failures++; $display("FAIL reset_dut_in got %0d want 0", dut_in_a); end
    checks++; if (busy_a !== 1'b0 || done_a !== 1'b0 || pass_a !== 1'b0) begin failures++; $display("FAIL reset_flags got busy=%b done=%b pass=%b want 000", busy_a, done_a, pass_a); end
    checks++; if (err_a !== 6'd0 || fpat_a !== 5'd0) begin failures++; $display("FAIL reset_err got %0d/%0d want 0/0", err_a, fpat_a); end
    checks++; if (sig_a !== 16'hFFFF) begin failures++; $display("FAIL reset_sig got %h want ffff", sig_a); end
    @(posedge clk); #1 rst = 0;
  endtask
  task automatic test_good_run;
    int dc; bit bo;
    fault = 0;
    run(0, 0, dc, bo);
    checks++; if (dc != 97) begin failures++; $display("FAIL good_done_cycle got %0d want 97", dc); end
    checks++; if (!bo) begin failures++; $display("FAIL good_busy got 0 in run want 1"); end
    checks++; if (err_a !== 6'd0) begin failures++; $display("FAIL good_err got %0d want 0", err_a); end
    checks++; if (sig_a !== exp_sig(0, 32)) begin failures++; $display("FAIL good_sig got %h want %h", sig_a, exp_sig(0, 32)); end
    @(posedge clk); #1;
    checks++; if (pass_a !== 1'b1) begin failures++; $display("FAIL good_pass got %b want 1", pass_a); end
    checks++; if (done_a !== 1'b0 || busy_a !== 1'b0) begin failures++; $display("FAIL good_after got done=%b busy=%b want 00", done_a, busy_a); end
  endtask
  task automatic test_n22_sa0;
    int dc; bit bo;
    fault = 1;
    run(0, 0, dc, bo);
    @(posedge clk); #1;
    checks++; if (err_a !== 6'd18) begin failures++; $display("FAIL n22_err got %0d want 18", err_a); end
    checks++; if (fpat_a !== 5'd8) begin failures++; $display("FAIL n22_first got %0d want 8", fpat_a); end
    checks++; if (pass_a !== 1'b0) begin failures++; $display("FAIL n22_pass got %b want 0", pass_a); end
    checks++; if (sig_a !== exp_sig(1, 32)) begin failures++; $display("FAIL n22_sig got %h want %h", sig_a, exp_sig(1, 32)); end
  endtask
  task automatic test_n23_sa1;
    int dc; bit bo;
    fault = 2;
    run(0, 0, dc, bo);
    @(posedge clk); #1;
    checks++; if (err_a !== 6'd14) begin failures++; $display("FAIL n23_err got %0d want 14", err_a); end
    checks++; if (fpat_a !== 5'd0) begin failures++; $display("FAIL n23_first got %0d want 0", fpat_a); end
    checks++; if (pass_a !== 1'b0) begin failures++; $display("FAIL n23_pass got %b want 0", pass_a); end
    fault = 0;
  endtask
  task automatic test_single;
    int dc; bit bo;
    run(1, 0, dc, bo);
    checks++; if (dc != 3) begin failures++; $display("FAIL single_done_cycle got %0d want 3", dc); end
    checks++; if (dut_in_b !== 5'd0) begin failures++; $display("FAIL single_dut_in got %0d want 0", dut_in_b); end
    checks++; if (sig_b !== 16'hEFDF) begin failures++; $display("FAIL single_sig got %h want efdf", sig_b); end
    @(posedge clk); #1;
    checks++; if (pass_b !== 1'b1 || err_b !== 6'd0) begin failures++; $display("FAIL single_pass got pass=%b err=%0d want 1/0", pass_b, err_b); end
  endtask
  task automatic test_mid_reset;
    int dc; bit bo; int n = 0;
    start_a = 1; @(posedge clk); #1 start_a = 0;
    while (dut_in_a !== 5'd10 && n < 100) begin @(posedge clk); #1; n++; end
    checks++; if (n >= 100) begin failures++; $display("FAIL midrst_reach got timeout want dut_in=10"); end
    rst = 1; #1;
    checks++; if (dut_in_a !== 5'd0 || busy_a !== 1'b0 || done_a !== 1'b0) begin failures++; $display("FAIL midrst_state got dut_in=%0d busy=%b done=%b want 0/0/0", dut_in_a, busy_a, done_a); end
    checks++; if (sig_a !== 16'hFFFF || err_a !== 6'd0 || pass_a !== 1'b0 || fpat_a !== 5'd0) begin failures++; $display("FAIL midrst_regs got sig=%h err=%0d pass=%b fp=%0d want ffff/0/0/0", sig_a, err_a, pass_a, fpat_a); end
    @(posedge clk); #1 rst = 0;
    run(0, 0, dc, bo);
    checks++; if (dc != 97 || err_a !== 6'd0) begin failures++; $display("FAIL midrst_rerun got cyc=%0d err=%0d want 97/0", dc, err_a); end
    @(posedge clk); #1;
    checks++; if (pass_a !== 1'b1) begin failures++; $display("FAIL midrst_pass got %b want 1", pass_a); end
  endtask
  task automatic test_back_to_back;
    int dc, d1, d2; bit bo;
    run(0, 20, dc, bo);
    checks++; if (dc != 97) begin failures++; $display("FAIL busystart_cycle got %0d want 97", dc); end
    checks++; if (sig_a !== exp_sig(0, 32)) begin failures++; $display("FAIL busystart_sig got %h want %h", sig_a, exp_sig(0, 32)); end
    @(posedge clk); #1;
    d1 = -1; d2 = -1;
    start_a = 1; @(posedge clk); #1;
    for (int c = 1; c <= 400 && d2 < 0; c++) begin
      if (done_a) begin if (d1 < 0) d1 = c; else d2 = c; end
      if (d2 < 0) begin @(posedge clk); #1; end
    end
    start_a = 0;
    checks++; if (d1 != 97 || d2 != 195) begin failures++; $display("FAIL held_start got %0d,%0d want 97,195", d1, d2); end
    @(posedge clk); #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    test_good_run;
    test_n22_sa0;
    test_n23_sa1;
    test_single;
    test_mid_reset;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/c17_bist.md
# c17_bist

Built-in self-test driver/checker for the c17 combinational core: the stimulus end and response end of its N-port interface. It applies exhaustive 5-bit patterns to inputs N1, N2, N3, N6 and N7, waits a programmable settle time, and captures N22 and N23. Each capture is compared against an internal golden model of c17 and folded into a 16-bit MISR signature. It sits beside the c17 instance and serves as the silicon and timing-closure check for the STA flow.

## Interface
- NUM_PAT, 32, number of patterns applied, range 1..32, patterns 0..NUM_PAT-1
- SETTLE, 1, extra wait cycles between apply and capture, range 0..15
- MISR_POLY, 16'h1021, MISR feedback polynomial
- MISR_SEED, 16'hFFFF, MISR value loaded on start
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  level sampled in IDLE; begins a run
- dut_in  out  5  {N1,N2,N3,N6,N7} driven to c17, registered
- dut_out  in  2  {N22,N23} returned from c17
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse at end of run
- pass  out  1  err_count==0 at done; held until next start
- err_count  out  6  patterns with any output mismatch, saturates at 63
- first_err_pat  out  5  pattern index of first mismatch, valid when err_count!=0
- signature  out  16  MISR value, final at done

## Operation
- FSM states: IDLE, APPLY, WAIT, CAPTURE, FINISH.
- IDLE with start=1: pat<=0, err_count<=0, pass<=0, signature<=MISR_SEED, dut_in<=0; go to APPLY.
- APPLY, 1 cycle: dut_in holds pat. Next state is WAIT if SETTLE>0, else CAPTURE.
- WAIT: stays SETTLE cycles, counted by a 4-bit down-counter.
- CAPTURE, 1 cycle: sample dut_out, compare with c17_model(dut_in), update signature and error state.
  - Model: N22 = (N1&N3) | (N2&~(N3&N6)); N23 = ~(N3&N6) & (N2|N7).
  - Mismatch: err_count += 1, saturating; if err_count was 0, first_err_pat <= pat.
  - MISR: sig <= ({sig[14:0],1'b0} ^ (sig[15] ? MISR_POLY : 0)) ^ {14'b0, dut_out}.
  - If pat==NUM_PAT-1, go to FINISH. Otherwise pat+=1, dut_in<=pat+1, go to APPLY.
- FINISH, 1 cycle: done=1, pass<=(err_count==0); go to IDLE.
- start outside IDLE is ignored. start held high in IDLE after FINISH begins a new run.

## Timing
- Reset values: dut_in=0, busy=0, done=0, pass=0, err_count=0, first_err_pat=0, signature=16'hFFFF, state IDLE.
- Reset mid-run aborts immediately to the reset values; no done pulse.
- Each pattern takes SETTLE+2 cycles. dut_in is stable for the whole pattern, so the c17 path budget is SETTLE+2 cycles.
- Counting from the edge that samples start, done is high in cycle NUM_PAT*(SETTLE+2)+1; busy is high in cycles 1..NUM_PAT*(SETTLE+2).
- dut_out is sampled only on the CAPTURE edge; X/glitches in other cycles have no effect.
- pat counter is 6 bits wide so that NUM_PAT=32 terminates without wrap-around.

## Structure
- Package c17_bist_pkg holds:
  - the state enum;
  - default MISR_POLY/MISR_SEED constants;
  - function c17_model(input [4:0] p) returning [1:0] {N22,N23}.
- Sub-module c17_misr: 16-bit MISR with load, enable, 2-bit data input and parameterized polynomial.

## Test plan
- Correct bench c17 model, NUM_PAT=32, SETTLE=1 -> done in cycle 97; err_count=0, pass=1.
- N22 stuck-at-0 -> err_count=18, first_err_pat=8, pass=0.
- N23 stuck-at-1 -> err_count=14, first_err_pat=0, pass=0.
- NUM_PAT=1, SETTLE=0, correct c17 -> dut_in=0, done in cycle 3, signature=16'hEFDF, pass=1.
- rst pulsed while pat=10, then start -> all outputs return to reset values; the new run completes a full 32 patterns with err_count=0.
- start pulsed while busy -> ignored; run length and signature are identical to the uninterrupted run.
